axi4_mm2s_mover: RTL and testbench
==================================

Name: axi4_mm2s_mover

Overview:
- Consumes the 72-bit command stream that the host-to-accelerator stream master produces and reads the described buffer from host memory over the ACP AXI4 read channel.
- Presents the read data as a 64-bit AXI4-Stream (h2s data path) toward custom hardware.
- Returns one 8-bit status word per command to the stream master's status input.
- Sits between the h2s stream master and the ACP read port.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, ACP read address width.
- C_M_AXI_DATA_WIDTH, 64, read data and stream width; only 64 is supported.
- C_MAX_BURST, 16, maximum beats per AR burst (ACP limit); legal range 1..16.
- C_PROT, 3'b010, value driven on M_AXI_ARPROT.
- C_CACHE, 4'b0011, value driven on M_AXI_ARCACHE.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous, active-high.
- S_AXIS_CMD_TDATA  in  72  command word.
- S_AXIS_CMD_TVALID  in  1  command valid.
- S_AXIS_CMD_TREADY  out  1  command accept.
- M_AXIS_STS_TDATA  out  8  status word.
- M_AXIS_STS_TVALID  out  1  status valid.
- M_AXIS_STS_TREADY  in  1  status accept.
- M_AXI_ARADDR  out  32  burst start address.
- M_AXI_ARLEN  out  8  beats-1.
- M_AXI_ARSIZE  out  3  constant 3'b011.
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR).
- M_AXI_ARCACHE  out  4  C_CACHE.
- M_AXI_ARPROT  out  3  C_PROT.
- M_AXI_ARVALID  out  1  address valid.
- M_AXI_ARREADY  in  1  address accept.
- M_AXI_RDATA  in  64  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last beat; ignored.
- M_AXI_RVALID  in  1  read valid.
- M_AXI_RREADY  out  1  read accept.
- M_AXIS_TDATA  out  64  stream data.
- M_AXIS_TLAST  out  1  end of frame.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TREADY  in  1  stream accept.

Behaviour:
- Command fields:
  - [22:0] BTT (bytes to transfer)
  - [30:24] reserved, ignored
  - [31] EOF
  - [63:32] SADDR
  - [67:64] TAG
  - [71:68] ignored
- Status fields:
  - [3:0] TAG
  - [4] INTERR
  - [5] DECERR
  - [6] SLVERR
  - [7] OKAY, which is 1 only when bits 6:4 are all 0.
- Reset values:
  - All VALID and READY outputs are 0, and the FSM is in IDLE.
  - ARADDR, ARLEN, STS_TDATA and the error accumulators are 0.
- FSM states: IDLE, CHECK, ADDR, DATA, STATUS.
- IDLE:
  - CMD_TREADY=1.
  - On TVALID&&TREADY, latch addr=SADDR, beats_left=BTT[22:3], tag, EOF; clear error bits; go to CHECK.
- CHECK (1 cycle):
  - If BTT==0, BTT[2:0]!=0 or SADDR[2:0]!=0, set INTERR and go to STATUS with no AXI traffic.
  - Otherwise go to ADDR.
- Burst sizing, computed in CHECK/DATA and registered:
  - burst = min(C_MAX_BURST, beats_left, (4096-addr[11:0])>>3).
  - A burst never crosses a 4 KB boundary.
  - ARLEN = burst-1, upper ARLEN bits 0.
- ADDR:
  - ARVALID=1; ARADDR and ARLEN are held stable until ARREADY.
  - On handshake, ARVALID drops next cycle; go to DATA.
  - One burst is outstanding at a time.
- DATA:
  - RREADY = M_AXIS_TREADY, M_AXIS_TVALID = M_AXI_RVALID, and TDATA = RDATA, all combinationally (zero-latency pass-through).
  - The beat counter decrements on each RVALID&&RREADY.
  - Beat count comes from the counter, never from RLAST.
  - RRESP==2'b10 sets SLVERR; 2'b11 sets DECERR. Bits are sticky for the command, and the transfer still completes all beats.
  - After the final beat of a burst: addr += burst*8, beats_left -= burst. If beats_left != 0 go to ADDR, else go to STATUS.
- TLAST is 1 only on the final beat of the final burst of a command with EOF=1.
- Outside DATA: M_AXIS_TVALID=0 and RREADY=0.
- STATUS:
  - STS_TVALID=1 with TDATA stable until STS_TREADY, then return to IDLE.
  - CMD_TREADY=0 in every state except IDLE.
- Address arithmetic is 32-bit and wraps modulo 2^32 with no error.
- rst asserted mid-transfer: all state is abandoned and outputs return to reset values next cycle. The system reset also resets the ACP interconnect, so no draining is done.

Test Plan:
- Single-burst command: BTT=64, SADDR=0x1000_0000, EOF=1, TAG=5 -> one AR with ARADDR=0x1000_0000, ARLEN=7; 8 stream beats, TLAST on beat 8 only; status 0x85.
- Multi-burst with 4 KB split: BTT=256, SADDR=0x1000_0FC0, EOF=0 -> ARs (0x1000_0FC0, len 7), (0x1000_1000, len 15), (0x1000_1080, len 7); 32 beats, no TLAST; status OKAY with the command's tag.
- Illegal commands: BTT=0, BTT=12 and SADDR=0x...04, each with TAG=3 -> no ARVALID ever; status 0x13 each.
- SLVERR mid-burst: BTT=32, RRESP=2'b10 on beat 2 -> all 4 beats forwarded; status bit6=1, bit7=0.
- Backpressure: M_AXIS_TREADY toggled 1010..., ARREADY delayed 5 cycles, STS_TREADY delayed 3 cycles -> RREADY tracks TREADY; ARADDR, ARLEN and STS_TDATA stable while waiting; no beats lost or duplicated.
- Reset mid-DATA: assert rst after beat 3 of 8 -> next cycle all valids/readies are 0 and state is IDLE; a following command completes normally.

Source files
------------

// File: rtl/axi4_mm2s_mover.sv
// Command-driven memory-to-stream mover: reads host buffers over AXI4 and streams them out as AXI4-Stream.
// One burst outstanding; R data passes straight through to the stream; one status word per command.
module axi4_mm2s_mover #(
  parameter int         C_M_AXI_ADDR_WIDTH = 32,
  parameter int         C_M_AXI_DATA_WIDTH = 64,
  parameter int         C_MAX_BURST        = 16,
  parameter logic [2:0] C_PROT             = 3'b010,
  parameter logic [3:0] C_CACHE            = 4'b0011
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [71:0]                   S_AXIS_CMD_TDATA,
  input  logic                          S_AXIS_CMD_TVALID,
  output logic                          S_AXIS_CMD_TREADY,
  output logic [7:0]                    M_AXIS_STS_TDATA,
  output logic                          M_AXIS_STS_TVALID,
  input  logic                          M_AXIS_STS_TREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic [3:0]                    M_AXI_ARCACHE,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                          M_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, STATUS} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [19:0]   beats_q, beats_d;
  logic [3:0]    tag_q, tag_d;
  logic          eof_q, eof_d, bad_q, bad_d;
  logic          interr_q, interr_d, slverr_q, slverr_d, decerr_q, decerr_d;
  logic [7:0]    arlen_q, arlen_d, beat_q, beat_d, sts_q, sts_d;
  logic [19:0]   burst;
  logic          last_beat, cmd_rdy;
  logic          unused_bits;

  // Largest burst that fits the beat budget, the ACP limit and the current 4 KB page.
  function automatic logic [7:0] burst_len(input logic [11:0] page_off, input logic [19:0] beats);
    logic [9:0]  to_4k;
    logic [19:0] b;
    to_4k = 10'((13'd4096 - {1'b0, page_off}) >> 3);
    b = 20'(C_MAX_BURST);
    if (beats < b) b = beats;
    if ({10'd0, to_4k} < b) b = {10'd0, to_4k};
    return 8'(b - 20'd1);
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    tag_d    = tag_q;
    eof_d    = eof_q;
    bad_d    = bad_q;
    interr_d = interr_q;
    slverr_d = slverr_q;
    decerr_d = decerr_q;
    arlen_d  = arlen_q;
    beat_d   = beat_q;
    sts_d    = sts_q;
    cmd_rdy           = 1'b0;
    M_AXI_ARVALID     = 1'b0;
    M_AXI_RREADY      = 1'b0;
    M_AXIS_TVALID     = 1'b0;
    M_AXIS_TLAST      = 1'b0;
    M_AXIS_STS_TVALID = 1'b0;
    burst     = {12'd0, arlen_q} + 20'd1;
    last_beat = (beat_q == arlen_q);
    unique case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (S_AXIS_CMD_TVALID) begin
          addr_d   = AW'(S_AXIS_CMD_TDATA[63:32]);
          beats_d  = S_AXIS_CMD_TDATA[22:3];
          tag_d    = S_AXIS_CMD_TDATA[67:64];
          eof_d    = S_AXIS_CMD_TDATA[31];
          bad_d    = (S_AXIS_CMD_TDATA[22:0] == 23'd0) || (S_AXIS_CMD_TDATA[2:0] != 3'd0)
                     || (S_AXIS_CMD_TDATA[34:32] != 3'd0);
          interr_d = 1'b0;
          slverr_d = 1'b0;
          decerr_d = 1'b0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (bad_q) begin
          interr_d = 1'b1;
          sts_d    = {1'b0, 1'b0, 1'b0, 1'b1, tag_q};
          state_d  = STATUS;
        end else begin
          arlen_d = burst_len(addr_q[11:0], beats_q);
          beat_d  = 8'd0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) state_d = DATA;
      end
      DATA: begin
        M_AXI_RREADY  = M_AXIS_TREADY;
        M_AXIS_TVALID = M_AXI_RVALID;
        M_AXIS_TLAST  = eof_q && last_beat && (beats_q == burst);
        if (M_AXI_RVALID && M_AXIS_TREADY) begin
          if (M_AXI_RRESP == 2'b10) slverr_d = 1'b1;
          if (M_AXI_RRESP == 2'b11) decerr_d = 1'b1;
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            addr_d  = addr_q + AW'(burst << 3);
            beats_d = beats_q - burst;
            beat_d  = 8'd0;
            if (beats_d != 20'd0) begin
              arlen_d = burst_len(addr_d[11:0], beats_d);
              state_d = ADDR;
            end else begin
              sts_d   = {~(slverr_d | decerr_d | interr_q), slverr_d, decerr_d, interr_q, tag_q};
              state_d = STATUS;
            end
          end
        end
      end
      STATUS: begin
        M_AXIS_STS_TVALID = 1'b1;
        if (M_AXIS_STS_TREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      beats_q  <= '0;
      tag_q    <= '0;
      eof_q    <= 1'b0;
      bad_q    <= 1'b0;
      interr_q <= 1'b0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
      arlen_q  <= '0;
      beat_q   <= '0;
      sts_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      tag_q    <= tag_d;
      eof_q    <= eof_d;
      bad_q    <= bad_d;
      interr_q <= interr_d;
      slverr_q <= slverr_d;
      decerr_q <= decerr_d;
      arlen_q  <= arlen_d;
      beat_q   <= beat_d;
      sts_q    <= sts_d;
    end
  end

  // Ready is held low while reset is asserted so no command is taken during reset.
  assign S_AXIS_CMD_TREADY = cmd_rdy && !rst;
  assign M_AXIS_STS_TDATA  = sts_q;
  assign M_AXI_ARADDR      = addr_q;
  assign M_AXI_ARLEN       = arlen_q;
  assign M_AXI_ARSIZE      = 3'b011;
  assign M_AXI_ARBURST     = 2'b01;
  assign M_AXI_ARCACHE     = C_CACHE;
  assign M_AXI_ARPROT      = C_PROT;
  assign M_AXIS_TDATA      = M_AXI_RDATA;
  assign unused_bits       = ^{S_AXIS_CMD_TDATA[71:68], S_AXIS_CMD_TDATA[30:23], M_AXI_RLAST};
endmodule

// File: tb/tb_axi4_mm2s_mover.sv
// Scoreboard bench for axi4_mm2s_mover: directed commands, AXI slave model, decoupled monitor.
module tb_axi4_mm2s_mover;
  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] cmd_tdata;
  logic        cmd_tvalid, cmd_tready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid, sts_tready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, rresp;
  logic [3:0]  arcache;
  logic        arvalid, arready;
  logic [63:0] rdata, tdata;
  logic        rlast, rvalid, rready, tlast, tvalid, tready;

  always #5 clk = ~clk;

  axi4_mm2s_mover dut (
    .clk(clk), .rst(rst),
    .S_AXIS_CMD_TDATA(cmd_tdata), .S_AXIS_CMD_TVALID(cmd_tvalid), .S_AXIS_CMD_TREADY(cmd_tready),
    .M_AXIS_STS_TDATA(sts_tdata), .M_AXIS_STS_TVALID(sts_tvalid), .M_AXIS_STS_TREADY(sts_tready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
    .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready), .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast), .M_AXIS_TVALID(tvalid),
    .M_AXIS_TREADY(tready)
  );

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct packed { logic [63:0] data; logic last; } beat_t;

  ar_t        exp_ar[$];
  beat_t      exp_beat[$];
  logic [7:0] exp_sts[$];
  ar_t        bursts[$];
  int errors = 0, checks = 0, sts_seen = 0, beats_seen = 0;
  int ar_delay = 0, sts_delay = 0;
  bit tready_toggle = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  function automatic logic [63:0] mem(input logic [31:0] a);
    return {a ^ 32'hA5A5_A5A5, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops expectations on every handshake and checks hold/tracking rules.
  logic        ar_wait_p, sts_wait_p;
  logic [31:0] ar_addr_p;
  logic [7:0]  ar_len_p, sts_p;
  initial begin
    ar_t e; beat_t b; logic [7:0] s;
    ar_wait_p = 0; sts_wait_p = 0; ar_addr_p = 0; ar_len_p = 0; sts_p = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_wait_p = 0; sts_wait_p = 0;
      end else begin
        if (ar_wait_p) begin
          check("ar_hold_valid", 64'(arvalid), 64'd1);
          check("ar_hold_addr", 64'(araddr), 64'(ar_addr_p));
          check("ar_hold_len", 64'(arlen), 64'(ar_len_p));
        end
        ar_wait_p = arvalid && !arready; ar_addr_p = araddr; ar_len_p = arlen;
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) fail("unexpected_ar");
          else begin
            e = exp_ar.pop_front();
            check("ar_addr", 64'(araddr), 64'(e.addr));
            check("ar_len", 64'(arlen), 64'(e.len));
            check("ar_consts", 64'({arsize, arburst, arcache, arprot}), 64'({3'b011, 2'b01, 4'b0011, 3'b010}));
          end
        end
        if (rvalid) begin
          check("rready_tracks_tready", 64'(rready), 64'(tready));
          check("tvalid_follows_rvalid", 64'(tvalid), 64'd1);
          check("tdata_passthru", tdata, rdata);
        end
        if (tvalid && tready) begin
          beats_seen++;
          if (exp_beat.size() == 0) fail("unexpected_beat");
          else begin
            b = exp_beat.pop_front();
            check("beat_data", tdata, b.data);
            check("beat_last", 64'(tlast), 64'(b.last));
          end
        end
        if (sts_wait_p) check("sts_hold", 64'({sts_tvalid, sts_tdata}), 64'({1'b1, sts_p}));
        sts_wait_p = sts_tvalid && !sts_tready; sts_p = sts_tdata;
        if (sts_tvalid && sts_tready) begin
          sts_seen++;
          if (exp_sts.size() == 0) fail("unexpected_status");
          else begin
            s = exp_sts.pop_front();
            check("status", 64'(sts_tdata), 64'(s));
          end
        end
      end
    end
  end

  // AXI read slave and stream/status sinks.
  initial begin
    bit rs, ar_hs, r_hs, s_hs;
    ar_t cap;
    int ar_cnt, r_idx, sts_cnt;
    logic [31:0] a;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; tready = 1; sts_tready = 0;
    ar_cnt = 0; r_idx = 0; sts_cnt = 0;
    forever begin
      @(negedge clk);
      rs = rst; ar_hs = arvalid && arready; r_hs = rvalid && rready; s_hs = sts_tvalid && sts_tready;
      cap = '{addr: araddr, len: arlen};
      @(posedge clk); #1;
      if (rs) begin
        bursts.delete(); r_idx = 0; ar_cnt = 0; sts_cnt = 0;
        arready = 0; rvalid = 0; sts_tready = 0; tready = 1;
      end else begin
        if (ar_hs) begin bursts.push_back(cap); ar_cnt = 0; end
        arready = arvalid && (ar_cnt >= ar_delay);
        if (arvalid && !arready) ar_cnt++;
        if (r_hs) begin
          r_idx++;
          if (r_idx > int'(bursts[0].len)) begin void'(bursts.pop_front()); r_idx = 0; end
        end
        rvalid = (bursts.size() > 0);
        if (rvalid) begin
          a = bursts[0].addr + 32'(r_idx * 8);
          rdata = mem(a);
          rresp = (a == err_addr) ? 2'b10 : 2'b00;
          rlast = (r_idx == int'(bursts[0].len));
        end
        tready = tready_toggle ? ~tready : 1'b1;
        if (s_hs) sts_cnt = 0;
        sts_tready = sts_tvalid && (sts_cnt >= sts_delay);
        if (sts_tvalid && !sts_tready) sts_cnt++;
      end
    end
  end

  task automatic issue(input logic [22:0] btt, input logic [31:0] saddr, input logic eof,
                       input logic [3:0] tag, input logic [7:0] sts);
    logic [71:0] c;
    int n, t;
    c = '0; c[71:68] = 4'hF; c[67:64] = tag; c[63:32] = saddr; c[31] = eof; c[30:24] = 7'h5A; c[22:0] = btt;
    exp_sts.push_back(sts);
    if (!sts[4]) begin
      n = int'(btt >> 3);
      for (int i = 0; i < n; i++)
        exp_beat.push_back('{data: mem(saddr + 32'(i * 8)), last: eof && (i == n - 1)});
    end
    @(posedge clk); #1;
    cmd_tdata = c; cmd_tvalid = 1;
    t = 0;
    forever begin
      @(negedge clk);
      if (cmd_tready) break;
      t++;
      if (t > 200) begin fail("cmd_accept_timeout"); break; end
    end
    @(posedge clk); #1;
    cmd_tvalid = 0;
  endtask

  task automatic send_cmd(input logic [22:0] btt, input logic [31:0] saddr, input logic eof,
                          input logic [3:0] tag, input logic [7:0] sts);
    int start, t;
    start = sts_seen;
    issue(btt, saddr, eof, tag, sts);
    t = 0;
    while (sts_seen == start && t < 3000) begin @(negedge clk); t++; end
    if (sts_seen == start) fail("status_timeout");
    check("ar_all_seen", 64'(exp_ar.size()), 64'd0);
    check("beats_all_seen", 64'(exp_beat.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_valids_readies", 64'({cmd_tready, arvalid, rready, tvalid, sts_tvalid}), 64'd0);
    check("rst_regs", 64'({araddr, arlen, sts_tdata}), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t;
    rst = 1; cmd_tdata = '0; cmd_tvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 0;
    @(posedge clk); #1;
    check("idle_cmd_ready", 64'(cmd_tready), 64'd1);

    // Single burst
    exp_ar.push_back('{addr: 32'h1000_0000, len: 8'd7});
    send_cmd(23'd64, 32'h1000_0000, 1'b1, 4'd5, 8'h85);

    // 4 KB split into three bursts
    exp_ar.push_back('{addr: 32'h1000_0FC0, len: 8'd7});
    exp_ar.push_back('{addr: 32'h1000_1000, len: 8'd15});
    exp_ar.push_back('{addr: 32'h1000_1080, len: 8'd7});
    send_cmd(23'd256, 32'h1000_0FC0, 1'b0, 4'd9, 8'h89);

    // Illegal commands: no AR traffic expected
    send_cmd(23'd0,  32'h1000_0000, 1'b1, 4'd3, 8'h13);
    send_cmd(23'd12, 32'h1000_0000, 1'b1, 4'd3, 8'h13);
    send_cmd(23'd64, 32'h1000_0004, 1'b1, 4'd3, 8'h13);

    // SLVERR on beat 2
    err_addr = 32'h4000_0008;
    exp_ar.push_back('{addr: 32'h4000_0000, len: 8'd3});
    send_cmd(23'd32, 32'h4000_0000, 1'b1, 4'd6, 8'h46);
    err_addr = 32'hFFFF_FFFF;

    // Address wrap across 2^32 (also a page boundary)
    exp_ar.push_back('{addr: 32'hFFFF_FFF0, len: 8'd1});
    exp_ar.push_back('{addr: 32'h0000_0000, len: 8'd1});
    send_cmd(23'd32, 32'hFFFF_FFF0, 1'b1, 4'd2, 8'h82);

    // Backpressure on every channel
    tready_toggle = 1; ar_delay = 5; sts_delay = 3;
    exp_ar.push_back('{addr: 32'h2000_0000, len: 8'd15});
    send_cmd(23'd128, 32'h2000_0000, 1'b1, 4'hA, 8'h8A);
    tready_toggle = 0; ar_delay = 0; sts_delay = 0;

    // Reset after beat 3 of 8
    base = beats_seen;
    exp_ar.push_back('{addr: 32'h3000_0000, len: 8'd7});
    issue(23'd64, 32'h3000_0000, 1'b1, 4'd4, 8'h84);
    t = 0;
    while (beats_seen < base + 3 && t < 500) begin @(negedge clk); t++; end
    if (beats_seen < base + 3) fail("reset_test_beat_timeout");
    @(posedge clk); #1;
    rst = 1;
    exp_ar.delete(); exp_beat.delete(); exp_sts.delete();
    @(posedge clk); #1;
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("post_reset_cmd_ready", 64'(cmd_tready), 64'd1);
    exp_ar.push_back('{addr: 32'h3000_0100, len: 8'd2});
    send_cmd(23'd24, 32'h3000_0100, 1'b1, 4'd1, 8'h81);

    repeat (5) @(posedge clk);
    check("no_stray_status", 64'(exp_sts.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
